// File: rtl/segm_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: the hex font,
// the segment bit positions inside seg, and the all-segments-off pattern.
package segm_pkg;

  // Bit positions inside the segment vector {dp,g,f,e,d,c,b,a}.
  typedef enum int unsigned {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  // Active-high pattern with every segment (and dp) dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high glyphs {g,f,e,d,c,b,a} for nibbles 0..F; b and d are lowercase.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/segm_font.sv
// Combinational hex-nibble to active-high segment decode; dp is left dark
// so the caller can merge its own decimal point.
module segm_font
  import segm_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] pat
);

  // Font lookup into the a..g field, dp cleared.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    pat                = SEG_OFF;
    pat[SEG_G:SEG_A]   = FONT[nib];
    pat[SEG_DP]        = 1'b0;
  end

endmodule

// File: rtl/segm_scan.sv
// Multiplexed 7-segment display scanner with per-frame input snapshot,
// per-digit blanking, decimal points and leading-zero suppression.
// Optional feature: define SEGM_SCAN_DIM_EN to add the 4-bit bright input
// and a free-running PWM that gates dig for brightness control.
module segm_scan
  import segm_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int TICK_DIV    = 250000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] num,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blank,
  input  logic              lz_en,
`ifdef SEGM_SCAN_DIM_EN
  input  logic [3:0]        bright,
`endif
  output logic [NDIG-1:0]   dig,
  output logic [7:0]        seg,
  output logic              frame
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;

  logic [CW-1:0]     cnt;
  logic              tick;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nxt_idx;
  logic              idx_wrap;

  logic [4*NDIG-1:0] snap_num;
  logic [NDIG-1:0]   snap_dp;
  logic [NDIG-1:0]   snap_blank;
  logic              snap_lz;

  logic [4*NDIG-1:0] src_num;
  logic [NDIG-1:0]   src_dp;
  logic [NDIG-1:0]   src_blank;
  logic              src_lz;

  logic [NDIG-1:0]   supp;
  logic              zrun;
  logic [3:0]        cur_nib;
  logic [7:0]        glyph;
  logic [7:0]        pat_hi;
  logic [7:0]        seg_nxt;

  logic [NDIG-1:0]   dig_q;

  assign tick     = (cnt == CW'(TICK_DIV - 1));
  assign idx_wrap = (idx == IW'(NDIG - 1));
  assign nxt_idx  = idx_wrap ? '0 : idx + 1'b1;

  // Prescaler: counts 0..TICK_DIV-1 and wraps on the slot tick.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Digit index: starts at the last digit so the first tick selects digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    idx <= IW'(NDIG - 1);
    else if (tick) idx <= nxt_idx;
  end

  // Frame snapshot: captured on the tick that selects digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the snapshot is a handful of flops, not a memory, so it is reset to a known value.
    if (!rst_n) begin
      snap_num   <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
    end else if (tick && idx_wrap) begin
      snap_num   <= num;
      snap_dp    <= dp;
      snap_blank <= blank;
      snap_lz    <= lz_en;
    end
  end

  // Digit 0 is rendered on the same edge the snapshot loads, so it must see
  // the live inputs; every later slot of the frame reads the snapshot.
  assign src_num   = idx_wrap ? num   : snap_num;
  assign src_dp    = idx_wrap ? dp    : snap_dp;
  assign src_blank = idx_wrap ? blank : snap_blank;
  assign src_lz    = idx_wrap ? lz_en : snap_lz;

  // Leading-zero mask: walk down from the top digit while the run of zeros lasts.
  always_comb begin
    supp = '0;
    zrun = src_lz;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (src_num[4*k +: 4] != 4'h0) zrun = 1'b0;
      supp[k] = zrun;
    end
  end

  assign cur_nib = src_num[4*int'(nxt_idx) +: 4];

  segm_font u_font (
    .nib (cur_nib),
    .pat (glyph)
  );

  // Pattern for the digit about to be selected, then polarity.
  always_comb begin
    pat_hi         = glyph;
    pat_hi[SEG_DP] = src_dp[nxt_idx];
    if (src_blank[nxt_idx] || supp[nxt_idx]) pat_hi = SEG_OFF;
    seg_nxt = SEG_ACT_LOW ? ~pat_hi : pat_hi;
  end

  // Output registers: dig/seg load on the tick, frame marks the digit-0 slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      seg   <= SEG_IDLE;
      frame <= 1'b0;
    end else begin
      frame <= tick && idx_wrap;
      if (tick) begin
        dig_q <= NDIG'(1) << nxt_idx;
        seg   <= seg_nxt;
      end
    end
  end

`ifdef SEGM_SCAN_DIM_EN
  logic [3:0] pwm;

  // Free-running brightness PWM; dig is lit while pwm <= bright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm + 1'b1;
  end

  assign dig = (pwm <= bright) ? dig_q : '0;
`else
  assign dig = dig_q;
`endif

endmodule

// File: tb/tb_segm_scan.sv
// Directed, table-driven bench for segm_scan (NDIG=4, TICK_DIV=4,
// active-low segments) plus a small NDIG=1 instance.
module tb_segm_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] num;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic        frame;

  logic [3:0]  num1;
  logic [0:0]  dig1;
  logic [7:0]  seg1;
  logic        frame1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segm_scan #(.NDIG(4), .TICK_DIV(4), .SEG_ACT_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .dp    (dp),
    .blank (blank),
    .lz_en (lz_en),
    .dig   (dig),
    .seg   (seg),
    .frame (frame)
  );

  segm_scan #(.NDIG(1), .TICK_DIV(2), .SEG_ACT_LOW(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num1),
    .dp    (1'b0),
    .blank (1'b0),
    .lz_en (1'b0),
    .dig   (dig1),
    .seg   (seg1),
    .frame (frame1)
  );

  typedef struct {
    logic [15:0]     num;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][7:0] exp;   // exp[k] = expected seg for digit k
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Waits (bounded) for the negedge at which frame is high.
  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (frame) found = 1'b1;
    end
    check("frame_seen", found, 1'b1);
  endtask

  logic [7:0] reset_seg [3];
  logic [3:0] exp_dig;

  initial begin
    //             num       dp       blank    lz    {d3,    d2,    d1,    d0}
    vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{16'h1234, 4'b0100, 4'b0100, 1'b0, {8'hF9, 8'hFF, 8'hB0, 8'h99}};
    vecs[4] = '{16'h1234, 4'b0100, 4'b0000, 1'b0, {8'hF9, 8'h24, 8'hB0, 8'h99}};
    vecs[5] = '{16'h0800, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'h80, 8'hC0, 8'hC0}};
    vecs[6] = '{16'h0001, 4'b1111, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h79}};
    vecs[7] = '{16'hCDE0, 4'b0000, 4'b0000, 1'b1, {8'hC6, 8'hA1, 8'h86, 8'hC0}};
    vecs[8] = '{16'h6789, 4'b0000, 4'b0000, 1'b0, {8'h82, 8'hF8, 8'h80, 8'h90}};

    reset_seg[0] = 8'h8E;
    reset_seg[1] = 8'h88;
    reset_seg[2] = 8'hA4;

    // Reset state.
    rst_n = 1'b0;
    num   = 16'h12AF;
    dp    = 4'b0000;
    blank = 4'b0000;
    lz_en = 1'b0;
    num1  = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_dig",   dig,   4'b0000);
    check("rst_seg",   seg,   8'hFF);
    check("rst_frame", frame, 1'b0);
    check("rst_dig1",  dig1,  1'b0);

    // Release and follow the first three slots cycle by cycle.
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_dig = (i < 4) ? 4'b0000 : (4'b0001 << ((i - 4) / 4));
      check($sformatf("start_dig_%0d", i),   dig,   exp_dig);
      check($sformatf("start_frame_%0d", i), frame, (i == 4));
      check($sformatf("start_seg_%0d", i),   seg,   (i < 4) ? 8'hFF : reset_seg[(i - 4) / 4]);
      check($sformatf("n1_dig_%0d", i),      dig1,  (i >= 2));
      check($sformatf("n1_frame_%0d", i),    frame1, (i % 2 == 0));
      if (i >= 2) check($sformatf("n1_seg_%0d", i), seg1, 8'h8E);
    end

    // Table-driven frames.
    for (int v = 0; v < 9; v++) begin
      num   = vecs[v].num;
      dp    = vecs[v].dp;
      blank = vecs[v].blank;
      lz_en = vecs[v].lz;
      wait_frame();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) repeat (4) @(negedge clk);
        check($sformatf("v%0d_dig%0d", v, k), dig, 4'b0001 << k);
        check($sformatf("v%0d_seg%0d", v, k), seg, vecs[v].exp[k]);
      end
    end

    // Input change mid-frame must not reach the current frame.
    num   = 16'h12AF;
    dp    = 4'b0000;
    blank = 4'b0000;
    lz_en = 1'b0;
    wait_frame();
    check("mid_seg0", seg, 8'h8E);
    repeat (8) @(negedge clk);
    check("mid_dig2", dig, 4'b0100);
    num = 16'h6789;
    check("mid_seg2", seg, 8'hA4);
    repeat (4) @(negedge clk);
    check("mid_dig3", dig, 4'b1000);
    check("mid_seg3", seg, 8'hF9);
    wait_frame();
    check("mid_new_seg0", seg, 8'h90);
    repeat (4) @(negedge clk);
    check("mid_new_seg1", seg, 8'h80);

    // Asynchronous reset mid-slot, away from any clock edge.
    repeat (1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_dig",   dig,   4'b0000);
    check("async_seg",   seg,   8'hFF);
    check("async_frame", frame, 1'b0);
    check("async_dig1",  dig1,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
